// File: rtl/audio_serial_tx_pkg.sv
// Shared definitions for the serial audio transmitter: register map, status
// bit positions, frame geometry and the sequencer state encoding.
package audio_pkg;

  localparam logic [3:0] AUD_ADDR_LEFT   = 4'd0;
  localparam logic [3:0] AUD_ADDR_RIGHT  = 4'd1;
  localparam logic [3:0] AUD_ADDR_CTRL   = 4'd2;
  localparam logic [3:0] AUD_ADDR_DIV    = 4'd3;
  localparam logic [3:0] AUD_ADDR_STATUS = 4'd4;

  localparam int ST_FULL     = 4;
  localparam int ST_EMPTY    = 5;
  localparam int ST_UNDERRUN = 6;
  localparam int ST_OVERFLOW = 7;

  localparam int SLOTS_PER_HALF = 32;
  localparam int SAMPLE_BITS    = 16;

  localparam logic [7:0] DIV_RESET = 8'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } aud_state_t;

  // Serial bit for a slot of a {left, right} pair: the first SAMPLE_BITS
  // slots of each half carry the sample MSB first, the rest are zero.
  function automatic logic slot_bit(input logic [31:0] pair, input logic [5:0] slot);
    logic [SAMPLE_BITS-1:0] sample;
    sample = slot[5] ? pair[15:0] : pair[31:16];
    if (slot[4]) return 1'b0;
    return sample[4'd15 - slot[3:0]];
  endfunction

endpackage

// File: rtl/audio_serial_tx_if.sv
// Local register bus seen by the audio transmitter.
// A write happens on a clock edge with En & Wr; DataRd is combinational from
// Addr and register state, and reads have no side effects.
interface audio_serial_tx_if;
  logic [3:0]  Addr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        En;
  logic        Rd;
  logic        Wr;

  modport master (output Addr, DataWr, En, Rd, Wr, input DataRd);
  modport slave  (input Addr, DataWr, En, Rd, Wr, output DataRd);
endinterface

// File: rtl/audio_serial_tx_fifo.sv
// Stereo sample FIFO: one {left, right} pair per entry, storage in flops so the
// head word is available straight from registers.
module audio_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_eff;
  logic             push_eff;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_eff  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_eff = push & (~full | pop_eff);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      if (push_eff && !pop_eff)      level <= level + 1'b1;
      else if (pop_eff && !push_eff) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/audio_serial_tx.sv
// Serial audio transmitter: register bus, sample FIFO and a 64-slot
// left-justified frame generator (AbitClk / Async / Asdo).
module audio_serial_tx
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  audio_serial_tx_if.slave        bus,
  output logic                    AbitClk,
  output logic                    Async,
  output logic                    Asdo,
  output aud_state_t              state_dbg
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   left_stage;
  logic [15:0]   right_last;
  logic          enable;
  logic [7:0]    div;
  logic [7:0]    div_act;
  logic [7:0]    presc;
  logic [5:0]    slot;
  logic [31:0]   frame;
  logic          underrun;
  logic          overflow;
  aud_state_t    state;

  logic          wr_en;
  logic          push;
  logic          pop_req;
  logic          tick;
  logic [5:0]    next_slot;
  logic [31:0]   pop_data;
  logic [31:0]   fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   status;
  logic          unused_rd;

  assign unused_rd = bus.Rd;
  assign state_dbg = state;
  assign wr_en     = bus.En & bus.Wr;
  assign push      = wr_en && (bus.Addr == AUD_ADDR_RIGHT);
  assign tick      = (presc == div_act);
  assign next_slot = slot + 6'd1;

  // Pops happen when leaving IDLE and on the falling bit-clock edge out of slot 63.
  assign pop_req = enable && ((state == IDLE) ||
                              (tick && AbitClk && (slot == 6'd63)));
  assign pop_data = fifo_empty ? 32'h0 : fifo_head;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (Clk),
    .resetn    (Resetn),
    .push      (push),
    .push_data ({left_stage, bus.DataWr}),
    .pop       (pop_req),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    status = '0;
    status[3:0]         = 4'(fifo_level);
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_UNDERRUN] = underrun;
    status[ST_OVERFLOW] = overflow;
  end

  always_comb begin
    bus.DataRd = 16'h0000;
    case (bus.Addr)
      AUD_ADDR_LEFT:   bus.DataRd = left_stage;
      AUD_ADDR_RIGHT:  bus.DataRd = right_last;
      AUD_ADDR_CTRL:   bus.DataRd = {15'h0000, enable};
      AUD_ADDR_DIV:    bus.DataRd = {8'h00, div};
      AUD_ADDR_STATUS: bus.DataRd = status;
      default:         bus.DataRd = 16'h0000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      left_stage <= '0;
      right_last <= '0;
      enable     <= 1'b0;
      div        <= DIV_RESET;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (bus.Addr)
          AUD_ADDR_LEFT:  left_stage <= bus.DataWr;
          AUD_ADDR_RIGHT: right_last <= bus.DataWr;
          AUD_ADDR_CTRL:  enable     <= bus.DataWr[0];
          AUD_ADDR_DIV:   div        <= bus.DataWr[7:0];
          default: ;
        endcase
      end
      // A new event in the same cycle as a clear keeps the bit set.
      underrun <= (underrun & ~(wr_en && bus.Addr == AUD_ADDR_STATUS && bus.DataWr[ST_UNDERRUN]))
                | (pop_req & fifo_empty);
      overflow <= (overflow & ~(wr_en && bus.Addr == AUD_ADDR_STATUS && bus.DataWr[ST_OVERFLOW]))
                | (push & fifo_full & ~pop_req);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state   <= IDLE;
      AbitClk <= 1'b0;
      Async   <= 1'b0;
      Asdo    <= 1'b0;
      presc   <= '0;
      div_act <= DIV_RESET;
      slot    <= '0;
      frame   <= '0;
    end else begin
      case (state)
        IDLE: begin
          AbitClk <= 1'b0;
          Async   <= 1'b0;
          Asdo    <= 1'b0;
          presc   <= '0;
          slot    <= '0;
          div_act <= div;
          if (enable) begin
            state <= LOAD;
            frame <= pop_data;
            Asdo  <= slot_bit(pop_data, 6'd0);
          end
        end
        default: begin
          if (!enable) begin
            state   <= IDLE;
            AbitClk <= 1'b0;
            Async   <= 1'b0;
            Asdo    <= 1'b0;
            presc   <= '0;
            slot    <= '0;
          end else begin
            if (state == LOAD) state <= RUN;
            if (tick) begin
              // A new divider is picked up only at a terminal count.
              presc   <= '0;
              div_act <= div;
              AbitClk <= ~AbitClk;
              if (AbitClk) begin
                slot <= next_slot;
                if (slot == 6'd63) begin
                  frame <= pop_data;
                  Async <= 1'b0;
                  Asdo  <= slot_bit(pop_data, 6'd0);
                end else begin
                  Async <= next_slot[5];
                  Asdo  <= slot_bit(frame, next_slot);
                end
              end
            end else begin
              presc <= presc + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_serial_tx.sv
// Directed bench for audio_serial_tx: register vectors from a table, then
// hand-written frame sequences checked bit by bit at the bit-clock rising edge.
module tb_audio_serial_tx;
  import audio_pkg::*;

  logic       Clk;
  logic       Resetn;
  logic       AbitClk;
  logic       Async;
  logic       Asdo;
  aud_state_t state_dbg;

  audio_serial_tx_if bus();

  audio_serial_tx #(.FIFO_DEPTH(4)) dut (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .bus       (bus),
    .AbitClk   (AbitClk),
    .Async     (Async),
    .Asdo      (Asdo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    bus.En = 1'b0; bus.Wr = 1'b0; bus.Rd = 1'b0; bus.Addr = '0; bus.DataWr = '0;
    Resetn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Resetn = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.Addr = a; bus.DataWr = d; bus.En = 1'b1; bus.Wr = 1'b1; bus.Rd = 1'b0;
    @(posedge Clk);
    #1;
    bus.En = 1'b0; bus.Wr = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [15:0] exp, input string name);
    bus.Addr = a; bus.En = 1'b1; bus.Rd = 1'b1; bus.Wr = 1'b0;
    #1;
    check(name, 64'(bus.DataRd), 64'(exp));
    bus.En = 1'b0; bus.Rd = 1'b0;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    wr(AUD_ADDR_LEFT, l);
    wr(AUD_ADDR_RIGHT, r);
  endtask

  // Collect Asdo/Async at each of the next n AbitClk rising edges (slot order,
  // earliest slot in the higher bit), plus timing of the bit clock.
  task automatic capture(input int n, input int div,
                         output logic [63:0] sd, output logic [63:0] sy,
                         output int lat, output int bad_gaps,
                         output int hi_len, output int span);
    int cyc = 0;
    int rises = 0;
    int first = 0;
    int last = 0;
    int limit;
    logic prev;
    limit = n * 2 * (div + 1) + div + 16;
    prev = AbitClk;
    sd = '0; sy = '0; lat = -1; bad_gaps = 0; hi_len = -1; span = 0;
    while (rises < n && cyc < limit) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (AbitClk && !prev) begin
        sd = {sd[62:0], Asdo};
        sy = {sy[62:0], Async};
        if (rises == 0) begin
          lat = cyc;
          first = cyc;
        end else if (cyc - last != 2 * (div + 1)) begin
          bad_gaps++;
        end
        last = cyc;
        rises++;
      end else if (!AbitClk && prev && hi_len < 0 && rises > 0) begin
        hi_len = cyc - last;
      end
      prev = AbitClk;
    end
    span = last - first;
    if (rises < n) check("capture_timeout_rises", 64'(rises), 64'(n));
  endtask

  logic [15:0] pl[5];
  logic [15:0] pr[5];

  function automatic logic [63:0] frame_exp(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  initial begin
    logic [63:0] sd, sy;
    int lat, gaps, hi, span;

    vecs[0]  = '{1'b0, 4'd0,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 4'd1,  16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 4'd2,  16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 4'd3,  16'h0000, 16'h0003};
    vecs[4]  = '{1'b0, 4'd4,  16'h0000, 16'h0020};
    vecs[5]  = '{1'b0, 4'd7,  16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 4'd3,  16'h12A7, 16'h0000};
    vecs[7]  = '{1'b0, 4'd3,  16'h0000, 16'h00A7};
    vecs[8]  = '{1'b1, 4'd0,  16'h1234, 16'h0000};
    vecs[9]  = '{1'b0, 4'd0,  16'h0000, 16'h1234};
    vecs[10] = '{1'b1, 4'd1,  16'hBEEF, 16'h0000};
    vecs[11] = '{1'b0, 4'd1,  16'h0000, 16'hBEEF};
    vecs[12] = '{1'b0, 4'd4,  16'h0000, 16'h0001};
    vecs[13] = '{1'b1, 4'd4,  16'h00C0, 16'h0000};
    vecs[14] = '{1'b0, 4'd4,  16'h0000, 16'h0001};
    vecs[15] = '{1'b1, 4'd2,  16'hFFFE, 16'h0000};
    vecs[16] = '{1'b0, 4'd2,  16'h0000, 16'h0000};
    vecs[17] = '{1'b1, 4'd15, 16'h5555, 16'h0000};
    vecs[18] = '{1'b0, 4'd15, 16'h0000, 16'h0000};

    pl[0] = 16'h1111; pr[0] = 16'h8001;
    pl[1] = 16'h2222; pr[1] = 16'h4002;
    pl[2] = 16'h3333; pr[2] = 16'h2004;
    pl[3] = 16'h4444; pr[3] = 16'h1008;
    pl[4] = 16'h5555; pr[4] = 16'h0810;

    // register table
    do_reset();
    check("reset_outputs", 64'({AbitClk, Async, Asdo}), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else rd_check(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
    end

    // basic frame at Div=0
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0000);
    push_pair(16'hA5C3, 16'h0F0F);
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(64, 0, sd, sy, lat, gaps, hi, span);
    check("basic_asdo", sd, frame_exp(16'hA5C3, 16'h0F0F));
    check("basic_async", sy, {32'h0000_0000, 32'hFFFF_FFFF});
    check("basic_first_rise", 64'(lat), 64'(2));
    check("basic_period", 64'(gaps), 64'(0));
    check("basic_high_len", 64'(hi), 64'(1));

    // underrun on empty FIFO
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0000);
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(64, 0, sd, sy, lat, gaps, hi, span);
    check("underrun_frame_zero", sd, 64'h0);
    wr(AUD_ADDR_CTRL, 16'h0000);
    rd_check(AUD_ADDR_STATUS, 16'h0060, "underrun_status_set");
    wr(AUD_ADDR_STATUS, 16'h0040);
    rd_check(AUD_ADDR_STATUS, 16'h0020, "underrun_status_clr");

    // overflow: 5 pushes into depth 4, then the 4 kept pairs in order
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0000);
    for (int i = 0; i < 5; i++) push_pair(pl[i], pr[i]);
    rd_check(AUD_ADDR_STATUS, 16'h0094, "overflow_status");
    wr(AUD_ADDR_CTRL, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      capture(64, 0, sd, sy, lat, gaps, hi, span);
      check($sformatf("overflow_frame%0d", i), sd, frame_exp(pl[i], pr[i]));
    end

    // divider 3
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0003);
    push_pair(16'h8001, 16'h7FFE);
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(64, 3, sd, sy, lat, gaps, hi, span);
    check("div3_asdo", sd, frame_exp(16'h8001, 16'h7FFE));
    check("div3_first_rise", 64'(lat), 64'(5));
    check("div3_period", 64'(gaps), 64'(0));
    check("div3_high_len", 64'(hi), 64'(4));
    check("div3_frame_span", 64'(span), 64'(63 * 8));

    // back-to-back frames, one push per frame
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0003);
    push_pair(pl[0], pr[0]);
    push_pair(pl[1], pr[1]);
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(64, 3, sd, sy, lat, gaps, hi, span);
    check("b2b_frame0", sd, frame_exp(pl[0], pr[0]));
    for (int k = 1; k < 4; k++) begin
      rd_check(AUD_ADDR_STATUS, 16'h0001, $sformatf("b2b_level%0d", k));
      push_pair(pl[k + 1], pr[k + 1]);
      capture(64, 3, sd, sy, lat, gaps, hi, span);
      check($sformatf("b2b_frame%0d", k), sd, frame_exp(pl[k], pr[k]));
      check($sformatf("b2b_period%0d", k), 64'(gaps), 64'(0));
    end

    // mid-frame disable, restart, then reset mid-frame
    do_reset();
    wr(AUD_ADDR_DIV, 16'h0000);
    push_pair(16'hA5C3, 16'h0F0F);
    push_pair(16'h1357, 16'h2468);
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(21, 0, sd, sy, lat, gaps, hi, span);
    check("abort_partial", 64'(sd[20:0]), 64'({16'hA5C3, 5'b00000}));
    wr(AUD_ADDR_CTRL, 16'h0000);
    @(posedge Clk);
    #1;
    check("abort_outputs", 64'({AbitClk, Async, Asdo}), 64'(0));
    check("abort_state", 64'(state_dbg), 64'(IDLE));
    rd_check(AUD_ADDR_STATUS, 16'h0001, "abort_fifo_kept");
    wr(AUD_ADDR_CTRL, 16'h0001);
    capture(40, 0, sd, sy, lat, gaps, hi, span);
    check("restart_asdo", 64'(sd[39:0]), 64'({16'h1357, 16'h0000, 8'h24}));
    check("restart_async", 64'(sy[39:0]), 64'(40'h00_0000_00FF));
    Resetn = 1'b0;
    @(posedge Clk);
    #1;
    check("midreset_outputs", 64'({AbitClk, Async, Asdo}), 64'(0));
    Resetn = 1'b1;
    rd_check(AUD_ADDR_STATUS, 16'h0020, "midreset_status");
    rd_check(AUD_ADDR_CTRL, 16'h0000, "midreset_ctrl");
    rd_check(AUD_ADDR_DIV, 16'h0003, "midreset_div");

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
